// File: rtl/instr_aligner_if.sv
// Handshake bundle between the instruction aligner, instruction memory, the
// redirect source and the decompressor/decoder downstream.
interface instr_aligner_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output flush, flush_pc, fetch_valid, fetch_data, instr_ready,
        input  fetch_addr, fetch_ready, instr_out, instr_pc, instr_compressed, instr_valid
    );

    modport slave (
        input  flush, flush_pc, fetch_valid, fetch_data, instr_ready,
        output fetch_addr, fetch_ready, instr_out, instr_pc, instr_compressed, instr_valid
    );
endinterface

// File: rtl/instr_aligner.sv
// Instruction aligner: turns a word-aligned fetch stream into one instruction per handshake.
// Define QUINTA_RVC_EN for mixed 16/32-bit (RVC) streams; default build is 32-bit only.
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    instr_aligner_if.slave bus
);

    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] faddr;
    logic        accept;
    logic        pop;

    assign bus.fetch_addr = faddr;
    assign bus.instr_pc   = pc;

`ifdef QUINTA_RVC_EN

    logic [15:0] slot0, slot1, slot2;
    logic [1:0]  count;
    logic        skip_low;
    logic        comp;
    logic        valid;
    logic [1:0]  pop_n;
    logic [1:0]  rem;
    logic [1:0]  count_nxt;
    logic [15:0] sh0, sh1;
    logic [15:0] slot0_nxt, slot1_nxt, slot2_nxt;

    assign comp  = (slot0[1:0] != 2'b11);
    assign valid = comp ? (count >= 2'd1) : (count >= 2'd2);
    assign pop   = valid && bus.instr_ready;
    assign pop_n = pop ? (comp ? 2'd1 : 2'd2) : 2'd0;
    assign rem   = count - pop_n;

    assign bus.fetch_ready      = (count <= 2'd1) && !bus.flush;
    assign accept               = bus.fetch_valid && bus.fetch_ready;
    assign bus.instr_valid      = valid;
    assign bus.instr_compressed = comp;
    assign bus.instr_out        = comp ? {16'h0000, slot0} : {slot1, slot0};

    // Pop first, then append the accepted halfwords behind what remains.
    always_comb begin
        sh0 = slot0;
        sh1 = slot1;
        if (pop_n == 2'd1) begin
            sh0 = slot1;
            sh1 = slot2;
        end else if (pop_n == 2'd2) begin
            sh0 = slot2;
            sh1 = slot2;
        end
        slot0_nxt = sh0;
        slot1_nxt = sh1;
        slot2_nxt = slot2;
        count_nxt = rem;
        if (accept) begin
            if (skip_low) begin
                count_nxt = rem + 2'd1;
                if (rem == 2'd0) slot0_nxt = bus.fetch_data[31:16];
                else             slot1_nxt = bus.fetch_data[31:16];
            end else begin
                count_nxt = rem + 2'd2;
                if (rem == 2'd0) {slot1_nxt, slot0_nxt} = bus.fetch_data;
                else             {slot2_nxt, slot1_nxt} = bus.fetch_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        slot0 <= slot0_nxt;
        slot1 <= slot1_nxt;
        slot2 <= slot2_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            skip_low <= RESET_PC[1];
            pc       <= RESET_PC;
            faddr    <= RESET_FETCH;
        end else if (bus.flush) begin
            count    <= 2'd0;
            skip_low <= bus.flush_pc[1];
            pc       <= bus.flush_pc;
            faddr    <= {bus.flush_pc[31:2], 2'b00};
        end else begin
            count <= count_nxt;
            if (accept) begin
                skip_low <= 1'b0;
                faddr    <= faddr + 32'd4;
            end
            if (pop) pc <= pc + (comp ? 32'd2 : 32'd4);
        end
    end

`else

    logic [31:0] word;
    logic        full;
    logic        unused_flush_bits;

    // Without RVC every word is one instruction, so the low PC bits carry nothing.
    assign unused_flush_bits = ^bus.flush_pc[1:0];

    assign pop                  = full && bus.instr_ready;
    assign bus.fetch_ready      = (!full || pop) && !bus.flush;
    assign accept               = bus.fetch_valid && bus.fetch_ready;
    assign bus.instr_valid      = full;
    assign bus.instr_compressed = 1'b0;
    assign bus.instr_out        = word;

    always_ff @(posedge clk) begin
        if (accept) word <= bus.fetch_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            pc    <= RESET_FETCH;
            faddr <= RESET_FETCH;
        end else if (bus.flush) begin
            full  <= 1'b0;
            pc    <= {bus.flush_pc[31:2], 2'b00};
            faddr <= {bus.flush_pc[31:2], 2'b00};
        end else begin
            if (accept)   full <= 1'b1;
            else if (pop) full <= 1'b0;
            if (accept) faddr <= faddr + 32'd4;
            if (pop)    pc    <= pc + 32'd4;
        end
    end

`endif

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed steps, then random traffic checked against an
// address-level model (expected stream = walk memory from the current PC).
module tb_instr_aligner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_aligner_if bus ();

    instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.flush_pc    = 32'h0;
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = 32'h0;
        bus.instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    // Pseudo-random instruction memory: a fixed hash of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00} * 32'h9E37_79B1;
        w = w ^ (w >> 15);
        w = w * 32'h85EB_CA6B;
        w = w ^ (w >> 13);
        return w;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    logic [31:0] m_pc, m_fa, fp, e_out, h0, len;
    logic        e_valid, e_ready, e_comp, r_rst, r_flush;
    int          avail;

    initial begin
        idle();

        // Reset state and first 32-bit word
        do_reset();
        check("rst_valid", bus.instr_valid, 0);
        check("rst_fready", bus.fetch_ready, 1);
        check("rst_faddr", bus.fetch_addr, 0);
        check("rst_pc", bus.instr_pc, 0);
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h00A0_0093;
        settle();
        check("acc_cycle_valid", bus.instr_valid, 0);
        tick();
        bus.fetch_valid = 1'b0;
        settle();
        check("w32_valid", bus.instr_valid, 1);
        check("w32_out", bus.instr_out, 32'h00A0_0093);
        check("w32_pc", bus.instr_pc, 0);
        check("w32_comp", bus.instr_compressed, 0);
        check("w32_faddr", bus.fetch_addr, 4);
        check("w32_fready_stall", bus.fetch_ready, 0);

`ifdef QUINTA_RVC_EN
        // Two c.li in one word
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h4501_4505;
        bus.instr_ready = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        settle();
        check("cli0_valid", bus.instr_valid, 1);
        check("cli0_out", bus.instr_out, 32'h0000_4505);
        check("cli0_pc", bus.instr_pc, 0);
        check("cli0_comp", bus.instr_compressed, 1);
        tick();
        check("cli1_valid", bus.instr_valid, 1);
        check("cli1_out", bus.instr_out, 32'h0000_4501);
        check("cli1_pc", bus.instr_pc, 2);
        check("cli1_comp", bus.instr_compressed, 1);
        tick();
        check("cli_drain_valid", bus.instr_valid, 0);
        check("cli_drain_pc", bus.instr_pc, 4);

        // Straddling 32-bit instruction, then backpressure with 3 halfwords held
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0093_4505;
        tick();
        bus.fetch_valid = 1'b0;
        bus.instr_ready = 1'b1;
        settle();
        check("str_c_out", bus.instr_out, 32'h0000_4505);
        check("str_c_comp", bus.instr_compressed, 1);
        tick();
        bus.instr_ready = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h4501_00A0;
        settle();
        check("str_half_valid", bus.instr_valid, 0);
        check("str_half_pc", bus.instr_pc, 2);
        check("str_half_fready", bus.fetch_ready, 1);
        tick();
        bus.fetch_data = 32'hDEAD_BEEF;
        settle();
        check("str_w_valid", bus.instr_valid, 1);
        check("str_w_out", bus.instr_out, 32'h00A0_0093);
        check("str_w_comp", bus.instr_compressed, 0);
        check("full_fready", bus.fetch_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_out", bus.instr_out, 32'h00A0_0093);
            check("hold_pc", bus.instr_pc, 2);
            check("hold_valid", bus.instr_valid, 1);
            check("hold_fready", bus.fetch_ready, 0);
            check("hold_faddr", bus.fetch_addr, 8);
        end
        bus.fetch_valid = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        check("rel_out", bus.instr_out, 32'h0000_4501);
        check("rel_pc", bus.instr_pc, 6);
        check("rel_comp", bus.instr_compressed, 1);
        tick();
        check("rel_drain_valid", bus.instr_valid, 0);
        check("rel_drain_pc", bus.instr_pc, 8);

        // Flush to an odd halfword while data is buffered
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0093_4505;
        tick();
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h0000_0102;
        bus.instr_ready = 1'b1;
        bus.fetch_data  = 32'hFFFF_FFFF;
        settle();
        check("flush_fready", bus.fetch_ready, 0);
        tick();
        idle();
        settle();
        check("flush_valid", bus.instr_valid, 0);
        check("flush_pc", bus.instr_pc, 32'h0000_0102);
        check("flush_faddr", bus.fetch_addr, 32'h0000_0100);
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h1234_4505;
        tick();
        bus.fetch_valid = 1'b0;
        settle();
        check("skip_valid", bus.instr_valid, 1);
        check("skip_out", bus.instr_out, 32'h0000_1234);
        check("skip_pc", bus.instr_pc, 32'h0000_0102);
        check("skip_comp", bus.instr_compressed, 1);
        check("skip_faddr", bus.fetch_addr, 32'h0000_0104);

        // Reset with half a 32-bit instruction buffered
        do_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h0093_4505;
        bus.instr_ready = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        settle();
        tick();
        check("half_valid", bus.instr_valid, 0);
        rst             = 1'b1;
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h0000_0200;
        bus.fetch_valid = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("rst2_valid", bus.instr_valid, 0);
        check("rst2_faddr", bus.fetch_addr, 0);
        check("rst2_pc", bus.instr_pc, 0);
        check("rst2_fready", bus.fetch_ready, 1);
`else
        // Pop and accept in the same cycle
        bus.instr_ready = 1'b1;
        settle();
        check("pop_fready", bus.fetch_ready, 1);
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h1111_1113;
        tick();
        check("b2b0_out", bus.instr_out, 32'h1111_1113);
        check("b2b0_pc", bus.instr_pc, 4);
        check("b2b0_faddr", bus.fetch_addr, 8);
        bus.fetch_data = 32'h2222_2223;
        tick();
        check("b2b1_out", bus.instr_out, 32'h2222_2223);
        check("b2b1_pc", bus.instr_pc, 8);
        check("b2b1_valid", bus.instr_valid, 1);

        // Flush: PC bit 1 is ignored
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0102;
        settle();
        check("flush_fready", bus.fetch_ready, 0);
        tick();
        idle();
        settle();
        check("flush_valid", bus.instr_valid, 0);
        check("flush_pc", bus.instr_pc, 32'h0000_0100);
        check("flush_faddr", bus.fetch_addr, 32'h0000_0100);
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = 32'h1234_4505;
        tick();
        bus.fetch_valid = 1'b0;
        settle();
        check("nrvc_out", bus.instr_out, 32'h1234_4505);
        check("nrvc_pc", bus.instr_pc, 32'h0000_0100);
        check("nrvc_comp", bus.instr_compressed, 0);

        // Reset discards the buffered word
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst2_valid", bus.instr_valid, 0);
        check("rst2_faddr", bus.fetch_addr, 0);
        check("rst2_pc", bus.instr_pc, 0);
        check("rst2_fready", bus.fetch_ready, 1);
`endif

        // Random traffic against the address-level model
        do_reset();
        m_pc = 32'h0;
        m_fa = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            r_rst   = ($urandom_range(0, 249) == 0);
            r_flush = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       fp = 32'hFFFF_FFF0 | ($urandom_range(0, 15) & 32'hE);
                1:       fp = $urandom_range(0, 255) & 32'hFFFF_FFFE;
                default: fp = $urandom & 32'hFFFF_FFFE;
            endcase
            rst             = r_rst;
            bus.flush       = r_flush;
            bus.flush_pc    = fp;
            bus.fetch_valid = ($urandom_range(0, 3) != 0);
            bus.fetch_data  = bus.fetch_valid ? mem_word(m_fa) : $urandom;
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            settle();

`ifdef QUINTA_RVC_EN
            // Halfwords fetched beyond the next PC; -1 while the low half is skipped.
            avail   = int'($signed(m_fa - m_pc)) / 2;
            h0      = {16'h0000, mem_hw(m_pc)};
            e_comp  = (h0[1:0] != 2'b11);
            e_valid = e_comp ? (avail >= 1) : (avail >= 2);
            e_ready = (avail <= 1) && !r_flush;
            e_out   = e_comp ? h0 : {mem_hw(m_pc + 32'd2), h0[15:0]};
            len     = e_comp ? 32'd2 : 32'd4;
`else
            avail   = int'($signed(m_fa - m_pc)) / 4;
            e_comp  = 1'b0;
            e_valid = (avail >= 1);
            e_ready = (!e_valid || bus.instr_ready) && !r_flush;
            e_out   = mem_word(m_pc);
            len     = 32'd4;
`endif
            check("rnd_valid", bus.instr_valid, e_valid);
            check("rnd_fready", bus.fetch_ready, e_ready);
            check("rnd_faddr", bus.fetch_addr, m_fa);
            check("rnd_pc", bus.instr_pc, m_pc);
            if (e_valid) begin
                check("rnd_out", bus.instr_out, e_out);
                check("rnd_comp", bus.instr_compressed, e_comp);
            end

            if (r_rst) begin
                m_pc = 32'h0;
                m_fa = 32'h0;
            end else if (r_flush) begin
`ifdef QUINTA_RVC_EN
                m_pc = fp;
`else
                m_pc = {fp[31:2], 2'b00};
`endif
                m_fa = {fp[31:2], 2'b00};
            end else begin
                if (bus.fetch_valid && e_ready) m_fa = m_fa + 32'd4;
                if (e_valid && bus.instr_ready) m_pc = m_pc + len;
            end
        end

        rst = 1'b0;
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
